// File: rtl/parking_password_entry_if.sv
// parking_password_entry_if: keypad/verdict inputs and password-entry outputs
interface parking_password_entry_if;
  logic       KEY_VALID;
  logic       KEY_BIT;
  logic       KEY_ENTER;
  logic       KEY_CLEAR;
  logic       Green;
  logic       Red;
  logic [3:0] PASSWORD;
  logic       PASS_VALID;
  logic [2:0] DIGIT_COUNT;
  logic       LOCKOUT;
  logic       TIMEOUT_PULSE;
  logic [1:0] ENTRY_STATE;
  modport master (
    output KEY_VALID, KEY_BIT, KEY_ENTER, KEY_CLEAR, Green, Red,
    input  PASSWORD, PASS_VALID, DIGIT_COUNT, LOCKOUT, TIMEOUT_PULSE, ENTRY_STATE
  );
  modport slave (
    input  KEY_VALID, KEY_BIT, KEY_ENTER, KEY_CLEAR, Green, Red,
    output PASSWORD, PASS_VALID, DIGIT_COUNT, LOCKOUT, TIMEOUT_PULSE, ENTRY_STATE
  );
endinterface

// File: rtl/parking_password_entry.sv
// parking_password_entry: collects a 4-bit keypad password, presents it for a verdict, and locks out after repeated failures
module parking_password_entry #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 32
) (
  input logic                     CLOCK,
  input logic                     RESET,
  parking_password_entry_if.slave bus
);
  localparam int TMAX = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
  typedef enum logic [1:0] {IDLE = 2'b00, COLLECT = 2'b01, PRESENT = 2'b10, LOCKED = 2'b11} state_t;
  state_t          r_state, w_state;
  logic [3:0]      r_sr, w_sr, r_pw, w_pw;
  logic [2:0]      r_cnt, w_cnt, r_att, w_att, w_att_inc;
  logic [TW-1:0]   r_timer, w_timer;
  logic            r_pv, w_pv, r_lock, w_lock, r_to, w_to;
  logic            w_idle_exp, w_lock_exp;
  assign w_idle_exp = r_timer == TW'(TIMEOUT_CYCLES - 1);
  assign w_lock_exp = r_timer == TW'(LOCKOUT_CYCLES - 1);
  assign w_att_inc  = r_att + 3'd1;
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_pw    <= '0;
      r_cnt   <= '0;
      r_att   <= '0;
      r_timer <= '0;
      r_pv    <= 1'b0;
      r_lock  <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sr    <= w_sr;
      r_pw    <= w_pw;
      r_cnt   <= w_cnt;
      r_att   <= w_att;
      r_timer <= w_timer;
      r_pv    <= w_pv;
      r_lock  <= w_lock;
      r_to    <= w_to;
    end
  end
  always_comb begin
    w_state = r_state;
    w_sr    = r_sr;
    w_pw    = r_pw;
    w_cnt   = r_cnt;
    w_att   = r_att;
    w_timer = r_timer;
    w_pv    = r_pv;
    w_lock  = r_lock;
    w_to    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.KEY_VALID && !bus.KEY_ENTER && !bus.KEY_CLEAR) begin
          w_sr    = {3'b000, bus.KEY_BIT};
          w_cnt   = 3'd1;
          w_timer = '0;
          w_state = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.KEY_CLEAR) begin
          w_sr    = '0;
          w_cnt   = '0;
          w_timer = '0;
          w_state = IDLE;
        end else if (bus.KEY_ENTER && r_cnt == 3'd4) begin
          w_pw    = r_sr;
          w_pv    = 1'b1;
          w_timer = '0;
          w_state = PRESENT;
        end else if (bus.KEY_VALID && !bus.KEY_ENTER) begin
          w_timer = '0;
          w_sr    = (r_cnt == 3'd4) ? r_sr : {r_sr[2:0], bus.KEY_BIT};
          w_cnt   = (r_cnt == 3'd4) ? r_cnt : r_cnt + 3'd1;
        end else if (w_idle_exp) begin
          w_sr    = '0;
          w_cnt   = '0;
          w_timer = '0;
          w_to    = 1'b1;
          w_state = IDLE;
        end else begin
          w_timer = r_timer + TW'(1);
        end
      end
      PRESENT: begin
        // Any exit from PRESENT withdraws the password
        if (bus.Green || bus.Red || w_idle_exp) begin
          w_pw    = '0;
          w_pv    = 1'b0;
          w_sr    = '0;
          w_cnt   = '0;
          w_timer = '0;
          w_state = IDLE;
          w_to    = !bus.Green && !bus.Red;
          w_att   = bus.Green ? 3'd0 : bus.Red ? w_att_inc : r_att;
          if (!bus.Green && bus.Red && w_att_inc == 3'(MAX_ATTEMPTS)) begin
            w_state = LOCKED;
            w_lock  = 1'b1;
          end
        end else begin
          w_timer = r_timer + TW'(1);
        end
      end
      LOCKED: begin
        w_state = w_lock_exp ? IDLE : LOCKED;
        w_lock  = !w_lock_exp;
        w_att   = w_lock_exp ? 3'd0 : r_att;
        w_timer = w_lock_exp ? '0 : r_timer + TW'(1);
      end
    endcase
  end
  assign bus.PASSWORD      = r_pw;
  assign bus.PASS_VALID    = r_pv;
  assign bus.DIGIT_COUNT   = r_cnt;
  assign bus.LOCKOUT       = r_lock;
  assign bus.TIMEOUT_PULSE = r_to;
  assign bus.ENTRY_STATE   = r_state;
endmodule

// File: doc/parking_password_entry.md
Name: parking_password_entry

Overview:
Upstream stage of CAR_Parking_System. Collects a 4-bit gate password one key press at a time from the entrance keypad and presents it as a stable PASSWORD word with a valid flag. It uses the downstream Green/Red verdict to count failed attempts, and locks the keypad after too many wrong entries. It also covers stale partial entries with a timeout, so the password FSM never sees half-typed codes.

Parameters:
TIMEOUT_CYCLES, 16, idle cycles allowed in COLLECT or PRESENT before abandoning entry (≥2)
MAX_ATTEMPTS, 3, consecutive Red verdicts that trigger lockout (1..7)
LOCKOUT_CYCLES, 32, cycles the keypad stays locked (≥1)

Ports:
CLOCK  input  1  system clock; all logic on rising edge
RESET  input  1  synchronous, active-high reset
KEY_VALID  input  1  one-cycle strobe: a bit key was pressed
KEY_BIT  input  1  value of pressed key (0/1), sampled with KEY_VALID
KEY_ENTER  input  1  one-cycle strobe: submit entry
KEY_CLEAR  input  1  one-cycle strobe: discard entry
Green  input  1  downstream verdict: password accepted
Red  input  1  downstream verdict: password rejected
PASSWORD  output  4  submitted password; first key pressed is MSB
PASS_VALID  output  1  PASSWORD is valid and awaiting verdict
DIGIT_COUNT  output  3  keys captured in current entry (0..4)
LOCKOUT  output  1  keypad locked
TIMEOUT_PULSE  output  1  one-cycle pulse when an entry is abandoned by timeout
ENTRY_STATE  output  2  00 IDLE, 01 COLLECT, 10 PRESENT, 11 LOCKED

Behaviour:
- Reset (RESET=1 at an edge, in any state, including mid-entry/lockout):
  - state IDLE; shift register, attempt counter and timer cleared.
  - All outputs 0: PASSWORD=0000, DIGIT_COUNT=0.
- All outputs are registered. An input sampled at edge N is visible after edge N.
- Strobe priority in the same cycle: KEY_CLEAR > KEY_ENTER > KEY_VALID.
- IDLE:
  - KEY_VALID: shift register = {000,KEY_BIT}, DIGIT_COUNT=1, timer=0, go COLLECT.
  - KEY_ENTER and KEY_CLEAR are ignored.
- COLLECT:
  - KEY_VALID with DIGIT_COUNT<4: shift register = {sr[2:0],KEY_BIT}, DIGIT_COUNT+1, timer=0.
  - KEY_VALID with DIGIT_COUNT=4: ignored (saturate); timer still reset to 0.
  - KEY_ENTER with DIGIT_COUNT=4: PASSWORD=sr, PASS_VALID=1, timer=0, go PRESENT.
  - KEY_ENTER with DIGIT_COUNT<4: ignored, no attempt counted.
  - KEY_CLEAR: sr=0, DIGIT_COUNT=0, go IDLE, no attempt counted.
  - No strobe: timer+1. When timer reaches TIMEOUT_CYCLES-1 with no strobe, go IDLE: DIGIT_COUNT=0, TIMEOUT_PULSE=1 for one cycle.
- PRESENT:
  - PASSWORD stays constant. All key strobes are ignored.
  - Green (wins if Green and Red are both high): attempts=0, PASS_VALID=0, PASSWORD=0000, DIGIT_COUNT=0, go IDLE.
  - Red: attempts+1.
    - If the new count equals MAX_ATTEMPTS: go LOCKED, LOCKOUT=1, timer=0.
    - Otherwise go IDLE.
    - Either way PASS_VALID=0, PASSWORD=0000, DIGIT_COUNT=0.
  - No verdict for TIMEOUT_CYCLES cycles: go IDLE with TIMEOUT_PULSE; attempts unchanged.
- LOCKED:
  - All strobes ignored; Green/Red ignored.
  - Timer counts to LOCKOUT_CYCLES-1, then go IDLE with LOCKOUT=0 and attempts=0.
- PASSWORD is 0000 in every state except PRESENT. DIGIT_COUNT is 0 in IDLE and LOCKED.
- Timer width is sized to the larger of TIMEOUT_CYCLES and LOCKOUT_CYCLES. Attempt counter is 3 bits and never wraps.

Test Plan:
1. RESET=1 for 2 edges with KEY_VALID toggling -> all outputs 0, ENTRY_STATE=00.
2. Keys 1,0,0,1 then ENTER -> one edge after ENTER: PASSWORD=1001, PASS_VALID=1, ENTRY_STATE=10. Then Green -> next edge PASS_VALID=0, PASSWORD=0000, ENTRY_STATE=00.
3. Keys 1,0,1,1,0 (fifth key ignored), ENTER -> PASSWORD=1011. Red repeated for 3 full entries (MAX_ATTEMPTS=3) -> after third Red LOCKOUT=1, ENTRY_STATE=11. 32 cycles later LOCKOUT=0; attempts reset, so one further Red does not lock.
4. Keys 1,1 then 16 idle cycles -> TIMEOUT_PULSE high exactly one cycle, DIGIT_COUNT=0, ENTRY_STATE=00. ENTER with 3 digits -> no PASS_VALID.
5. Same-cycle KEY_CLEAR+KEY_ENTER with 4 digits -> IDLE, no PASS_VALID. Same-cycle Green+Red in PRESENT -> treated as Green, attempts=0.
6. RESET asserted in PRESENT and in LOCKED -> next edge all outputs 0, ENTRY_STATE=00, attempt counter cleared (MAX_ATTEMPTS-1 Reds afterwards do not lock).
